// File: rtl/demux_4channel_tdm.sv
// Receive side of the 4-channel TDM link: aligns on FRAME_SYNC, buffers slots 0..2,
// and presents all four channels together once each complete frame has arrived.
module demux_4channel_tdm #(
  parameter int WIDTH       = 1,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WIDTH-1:0]       DATA_IN,
  input  logic                   SAMPLE_EN,
  input  logic                   FRAME_SYNC,
  output logic [WIDTH-1:0]       OUTPUT_1,
  output logic [WIDTH-1:0]       OUTPUT_2,
  output logic [WIDTH-1:0]       OUTPUT_3,
  output logic [WIDTH-1:0]       OUTPUT_4,
  output logic                   FRAME_VALID,
  output logic                   LOCKED,
  output logic                   SYNC_ERROR,
  output logic [1:0]             SLOT,
  output logic [FRAME_CNT_W-1:0] FRAME_COUNT
);

  // HUNT: waiting for sync | ACQ: first frame after sync | TRACK: aligned
  typedef enum logic [1:0] {HUNT, ACQ, TRACK} state_t;

  state_t                 state_q;
  logic [1:0]             slot_q;
  logic [WIDTH-1:0]       shadow_q [0:2];
  logic [WIDTH-1:0]       out_q [0:3];
  logic                   frame_valid_q;
  logic                   locked_q;
  logic                   sync_error_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_error_q  <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;
      if (SAMPLE_EN) begin
        if (state_q == HUNT) begin
          if (FRAME_SYNC) begin
            shadow_q[0] <= DATA_IN;
            slot_q      <= 2'd1;
            state_q     <= ACQ;
          end
        end else if (slot_q == 2'd0) begin
          if (FRAME_SYNC) begin
            shadow_q[0] <= DATA_IN;
            slot_q      <= 2'd1;
          end else begin
            sync_error_q <= 1'b1;
            state_q      <= HUNT;
            locked_q     <= 1'b0;
          end
        end else if (FRAME_SYNC) begin
          // early sync restarts the frame with this sample as slot 0
          sync_error_q <= 1'b1;
          shadow_q[0]  <= DATA_IN;
          slot_q       <= 2'd1;
          state_q      <= ACQ;
          locked_q     <= 1'b0;
        end else begin
          slot_q <= slot_q + 2'd1;
          case (slot_q)
            2'd1: shadow_q[1] <= DATA_IN;
            2'd2: shadow_q[2] <= DATA_IN;
            default: begin
              out_q[0]      <= shadow_q[0];
              out_q[1]      <= shadow_q[1];
              out_q[2]      <= shadow_q[2];
              out_q[3]      <= DATA_IN;
              frame_valid_q <= 1'b1;
              frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
              state_q       <= TRACK;
              locked_q      <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign OUTPUT_1    = out_q[0];
  assign OUTPUT_2    = out_q[1];
  assign OUTPUT_3    = out_q[2];
  assign OUTPUT_4    = out_q[3];
  assign FRAME_VALID = frame_valid_q;
  assign LOCKED      = locked_q;
  assign SYNC_ERROR  = sync_error_q;
  assign SLOT        = slot_q;
  assign FRAME_COUNT = frame_count_q;

endmodule

// File: tb/tb_demux_4channel_tdm.sv
// Directed bench: a byte-wide instance and a 1-bit instance with a 2-bit frame
// counter share one stimulus stream (the narrow one sees bit 0 of the data).
module tb_demux_4channel_tdm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       sample_en;
  logic       frame_sync;

  logic [7:0] oa1, oa2, oa3, oa4, ca;
  logic       va, la, ea;
  logic [1:0] sa;
  logic       ob1, ob2, ob3, ob4, vb, lb, eb;
  logic [1:0] sb, cb;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  demux_4channel_tdm #(.WIDTH(8), .FRAME_CNT_W(8)) dut_a (
    .CLK(clk), .RESET(rst), .DATA_IN(data_in), .SAMPLE_EN(sample_en),
    .FRAME_SYNC(frame_sync), .OUTPUT_1(oa1), .OUTPUT_2(oa2), .OUTPUT_3(oa3),
    .OUTPUT_4(oa4), .FRAME_VALID(va), .LOCKED(la), .SYNC_ERROR(ea),
    .SLOT(sa), .FRAME_COUNT(ca)
  );

  demux_4channel_tdm #(.WIDTH(1), .FRAME_CNT_W(2)) dut_b (
    .CLK(clk), .RESET(rst), .DATA_IN(data_in[0]), .SAMPLE_EN(sample_en),
    .FRAME_SYNC(frame_sync), .OUTPUT_1(ob1), .OUTPUT_2(ob2), .OUTPUT_3(ob3),
    .OUTPUT_4(ob4), .FRAME_VALID(vb), .LOCKED(lb), .SYNC_ERROR(eb),
    .SLOT(sb), .FRAME_COUNT(cb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input logic [7:0] e1, e2, e3, e4);
    chk({tag, ".out1"}, 32'(oa1), 32'(e1));
    chk({tag, ".out2"}, 32'(oa2), 32'(e2));
    chk({tag, ".out3"}, 32'(oa3), 32'(e3));
    chk({tag, ".out4"}, 32'(oa4), 32'(e4));
  endtask

  task automatic chk_b(input string tag, input logic e1, e2, e3, e4);
    chk({tag, ".b_outs"}, 32'({ob1, ob2, ob3, ob4}), 32'({e1, e2, e3, e4}));
  endtask

  // inputs change 1 time unit after the edge, outputs are sampled at the same point
  task automatic step(input logic en, input logic sync, input logic [7:0] d);
    sample_en  = en;
    frame_sync = sync;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cb[5];
    exp_cb = '{1, 2, 3, 0, 1};
    rst = 1'b1;
    step(0, 0, 8'h00);
    step(1, 1, 8'hFF);
    rst = 1'b0;

    // reset state
    chk_a("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.valid", 32'(va), 0);
    chk("reset.locked", 32'(la), 0);
    chk("reset.err", 32'(ea), 0);
    chk("reset.slot", 32'(sa), 0);
    chk("reset.count", 32'(ca), 0);
    chk("reset.count_b", 32'(cb), 0);

    // basic frame 0,1,0,1
    step(1, 1, 8'h00); chk("t1.slot1", 32'(sa), 1); chk("t1.acq_unlocked", 32'(la), 0);
    step(1, 0, 8'h01); chk("t1.slot2", 32'(sa), 2);
    step(1, 0, 8'h00); chk("t1.slot3", 32'(sa), 3); chk("t1.no_valid_yet", 32'(va), 0);
    step(1, 0, 8'h01);
    chk_a("t1", 8'h00, 8'h01, 8'h00, 8'h01);
    chk_b("t1", 0, 1, 0, 1);
    chk("t1.valid", 32'(va), 1);
    chk("t1.locked", 32'(la), 1);
    chk("t1.count", 32'(ca), 1);
    chk("t1.count_b", 32'(cb), 1);
    chk("t1.slot0", 32'(sa), 0);
    step(0, 0, 8'h00); chk("t1.valid_pulse", 32'(va), 0);

    // frames with idle gaps; sync while idle must be ignored
    step(1, 1, 8'h11); chk("t2.slot1", 32'(sa), 1);
    step(0, 1, 8'h99); chk("t2.idle_slot", 32'(sa), 1); chk("t2.idle_err", 32'(ea), 0);
    step(1, 0, 8'h22); chk("t2.slot2", 32'(sa), 2);
    step(0, 0, 8'h00);
    step(1, 0, 8'h33); chk("t2.slot3", 32'(sa), 3);
    chk_a("t2.held", 8'h00, 8'h01, 8'h00, 8'h01);
    step(0, 0, 8'h00);
    step(1, 0, 8'h44);
    chk_a("t2.f1", 8'h11, 8'h22, 8'h33, 8'h44);
    chk_b("t2.f1", 1, 0, 1, 0);
    chk("t2.valid", 32'(va), 1);
    chk("t2.count", 32'(ca), 2);
    step(0, 0, 8'h00);
    step(1, 1, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    step(1, 0, 8'hA4);
    chk_a("t2.f2", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    chk_b("t2.f2", 1, 0, 1, 0);
    chk("t2.count2", 32'(ca), 3);
    chk("t2.count2_b", 32'(cb), 3);

    // early sync on slot 2
    step(1, 1, 8'hB1);
    step(1, 0, 8'hB2); chk("t3.slot2", 32'(sa), 2);
    step(1, 1, 8'hC1);
    chk("t3.err", 32'(ea), 1);
    chk("t3.locked", 32'(la), 0);
    chk("t3.valid", 32'(va), 0);
    chk("t3.slot", 32'(sa), 1);
    chk_a("t3.held", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    step(0, 0, 8'h00); chk("t3.err_pulse", 32'(ea), 0);
    step(1, 0, 8'hC2);
    step(1, 0, 8'hC3);
    step(1, 0, 8'hC4);
    chk_a("t3.f", 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    chk("t3.f_valid", 32'(va), 1);
    chk("t3.f_locked", 32'(la), 1);
    chk("t3.count", 32'(ca), 4);
    chk("t3.count_b_wrap", 32'(cb), 0);

    // missing sync at slot 0
    step(1, 0, 8'hD0);
    chk("t4.err", 32'(ea), 1);
    chk("t4.locked", 32'(la), 0);
    chk("t4.slot", 32'(sa), 0);
    chk_a("t4.held", 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    step(1, 0, 8'hE1); chk("t4.hunt_err", 32'(ea), 0); chk("t4.hunt_slot", 32'(sa), 0);
    step(1, 0, 8'hE2); chk("t4.hunt_slot2", 32'(sa), 0); chk("t4.hunt_valid", 32'(va), 0);
    step(1, 1, 8'hF1); chk("t4.resync_slot", 32'(sa), 1);
    step(1, 0, 8'hF2);
    step(1, 0, 8'hF3);
    step(1, 0, 8'hF4);
    chk_a("t4.f", 8'hF1, 8'hF2, 8'hF3, 8'hF4);
    chk("t4.locked_again", 32'(la), 1);
    chk("t4.count", 32'(ca), 5);
    chk("t4.count_b", 32'(cb), 1);

    // reset mid-frame, overriding active inputs
    step(1, 1, 8'h55);
    step(1, 0, 8'h66);
    rst = 1'b1;
    step(1, 1, 8'h77);
    rst = 1'b0;
    chk_a("t5.reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t5.slot", 32'(sa), 0);
    chk("t5.locked", 32'(la), 0);
    chk("t5.count", 32'(ca), 0);
    chk("t5.valid", 32'(va), 0);
    step(1, 0, 8'h70); chk("t5.discard", 32'(sa), 0);
    step(1, 1, 8'h71);
    step(1, 0, 8'h72);
    step(1, 0, 8'h73);
    step(1, 0, 8'h74);
    chk_a("t5.f", 8'h71, 8'h72, 8'h73, 8'h74);
    chk("t5.f_count", 32'(ca), 1);

    // narrow counter wraps 1,2,3,0,1
    rst = 1'b1;
    step(0, 0, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 8'h01);
      step(1, 0, 8'h00);
      step(1, 0, 8'h01);
      step(1, 0, 8'(k));
      chk($sformatf("t6.count_b%0d", k), 32'(cb), 32'(exp_cb[k]));
      chk($sformatf("t6.count_a%0d", k), 32'(ca), 32'(k + 1));
      step(0, 0, 8'h00);
    end
    chk_b("t6.last", 1, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
